// File: rtl/alu_cmd_issuer_if.sv
// Request/response handshake bundle between a command producer and alu_cmd_issuer.
interface alu_cmd_issuer_if #(
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned CMD_WIDTH     = 4
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_mode;
  logic [CMD_WIDTH-1:0]       req_cmd;
  logic [1:0]                 req_inp_valid;
  logic [OPERAND_WIDTH-1:0]   req_opa;
  logic [OPERAND_WIDTH-1:0]   req_opb;
  logic                       req_cin;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [2*OPERAND_WIDTH-1:0] rsp_res;
  logic                       rsp_err;
  logic                       rsp_oflow;
  logic                       rsp_cout;
  logic [2:0]                 rsp_egl;

  modport master (
    output req_valid, req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin,
    input  req_ready,
    input  rsp_valid, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_egl,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_mode, req_cmd, req_inp_valid, req_opa, req_opb, req_cin,
    output req_ready,
    output rsp_valid, rsp_res, rsp_err, rsp_oflow, rsp_cout, rsp_egl,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Queues ALU operations, drives each on the registered ALU for its latency and returns results in
// order. Define ALU_ISSUE_STATS_EN to add saturating stat_ops/stat_errs counters.
module alu_cmd_issuer #(
  parameter int unsigned OPERAND_WIDTH = 8,
  parameter int unsigned CMD_WIDTH     = 4,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  alu_cmd_issuer_if.slave            bus,
  output logic                       CE,
  output logic                       MODE,
  output logic                       CIN,
  output logic [CMD_WIDTH-1:0]       CMD,
  output logic [1:0]                 INP_VALID,
  output logic [OPERAND_WIDTH-1:0]   OPA,
  output logic [OPERAND_WIDTH-1:0]   OPB,
  input  logic [2*OPERAND_WIDTH-1:0] alu_res,
  input  logic                       alu_err,
  input  logic                       alu_oflow,
  input  logic                       alu_cout,
  input  logic                       alu_e,
  input  logic                       alu_g,
  input  logic                       alu_l,
  output logic                       busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]                stat_ops,
  output logic [15:0]                stat_errs
`endif
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic                     mode;
    logic [CMD_WIDTH-1:0]     cmd;
    logic [1:0]               inp_valid;
    logic [OPERAND_WIDTH-1:0] opa;
    logic [OPERAND_WIDTH-1:0] opb;
    logic                     cin;
  } req_t;

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e state_q, state_d;

  req_t            mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            ready_q, ready_d;
  logic            push, pop;

  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      lat;
  req_t            drv_q, drv_d;
  logic            ce_q, ce_d;

  logic                       rsp_valid_q, rsp_valid_d;
  logic [2*OPERAND_WIDTH-1:0] rsp_res_q, rsp_res_d;
  logic                       rsp_err_q, rsp_err_d;
  logic                       rsp_oflow_q, rsp_oflow_d;
  logic                       rsp_cout_q, rsp_cout_d;
  logic [2:0]                 rsp_egl_q, rsp_egl_d;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d, stat_errs_q, stat_errs_d;
`endif

  // Multiplies need one extra pipeline stage in the ALU.
  assign lat = (drv_q.mode && (drv_q.cmd == CMD_WIDTH'(9) || drv_q.cmd == CMD_WIDTH'(10))) ?
               2'd3 : 2'd2;

  assign push = bus.req_valid && ready_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drv_d       = drv_q;
    ce_d        = ce_q;
    pop         = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_res_d   = rsp_res_q;
    rsp_err_d   = rsp_err_q;
    rsp_oflow_d = rsp_oflow_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_egl_d   = rsp_egl_q;
`ifdef ALU_ISSUE_STATS_EN
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          drv_d   = mem[rd_ptr_q];
          ce_d    = 1'b1;
          cnt_d   = 2'd0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == lat) begin
          rsp_valid_d = 1'b1;
          rsp_res_d   = alu_res;
          rsp_err_d   = alu_err;
          rsp_oflow_d = alu_oflow;
          rsp_cout_d  = alu_cout;
          rsp_egl_d   = {alu_e, alu_g, alu_l};
          ce_d        = 1'b0;
          state_d     = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
`ifdef ALU_ISSUE_STATS_EN
          if (stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
          if (rsp_err_q && stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    ready_d  = (count_d != CntW'(FIFO_DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
      drv_q       <= '0;
      ce_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_oflow_q <= 1'b0;
      rsp_cout_q  <= 1'b0;
      rsp_egl_q   <= '0;
`ifdef ALU_ISSUE_STATS_EN
      stat_ops_q  <= '0;
      stat_errs_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      drv_q       <= drv_d;
      ce_q        <= ce_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_res_q   <= rsp_res_d;
      rsp_err_q   <= rsp_err_d;
      rsp_oflow_q <= rsp_oflow_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_egl_q   <= rsp_egl_d;
`ifdef ALU_ISSUE_STATS_EN
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= '{mode: bus.req_mode, cmd: bus.req_cmd, inp_valid: bus.req_inp_valid,
                         opa: bus.req_opa, opb: bus.req_opb, cin: bus.req_cin};
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_res   = rsp_res_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_oflow = rsp_oflow_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_egl   = rsp_egl_q;

  assign CE        = ce_q;
  assign MODE      = drv_q.mode;
  assign CIN       = drv_q.cin;
  assign CMD       = drv_q.cmd;
  assign INP_VALID = drv_q.inp_valid;
  assign OPA       = drv_q.opa;
  assign OPB       = drv_q.opb;
  assign busy      = (state_q != StIdle) || (count_q != '0);

`ifdef ALU_ISSUE_STATS_EN
  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural ALU whose outputs are valid only after
// CE has been held high for the operation's pipeline latency.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce, mode, cin;
  logic [3:0]  cmd;
  logic [1:0]  inp_valid;
  logic [7:0]  opa, opb;
  logic [15:0] alu_res;
  logic        alu_err, alu_oflow, alu_cout, alu_e, alu_g, alu_l;
  logic        busy;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] stat_ops, stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int ce_run = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer_if #(.OPERAND_WIDTH(8), .CMD_WIDTH(4)) bus ();

  alu_cmd_issuer #(.OPERAND_WIDTH(8), .CMD_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .CLK       (clk),
    .RST       (rst),
    .bus       (bus),
    .CE        (ce),
    .MODE      (mode),
    .CIN       (cin),
    .CMD       (cmd),
    .INP_VALID (inp_valid),
    .OPA       (opa),
    .OPB       (opb),
    .alu_res   (alu_res),
    .alu_err   (alu_err),
    .alu_oflow (alu_oflow),
    .alu_cout  (alu_cout),
    .alu_e     (alu_e),
    .alu_g     (alu_g),
    .alu_l     (alu_l),
    .busy      (busy)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_errs (stat_errs)
`endif
  );

  // ALU stand-in: results appear only once CE has been high for LAT sampled edges.
  always @(posedge clk) ce_run <= ce ? ce_run + 1 : 0;

  always_comb begin
    alu_res   = '0;
    alu_err   = 1'b0;
    alu_oflow = 1'b0;
    alu_cout  = 1'b0;
    alu_e     = 1'b0;
    alu_g     = 1'b0;
    alu_l     = 1'b0;
    if (ce_run >= ((mode && (cmd == 4'd9 || cmd == 4'd10)) ? 3 : 2)) begin
      if (inp_valid != 2'b11) begin
        alu_err = 1'b1;
      end else if (mode) begin
        case (cmd)
          4'd0: begin
            alu_res  = 16'(opa) + 16'(opb);
            alu_cout = alu_res[8];
          end
          4'd8: begin
            alu_e = (opa == opb);
            alu_g = (opa > opb);
            alu_l = (opa < opb);
          end
          4'd9:    alu_res = (16'(opa) + 16'd1) * (16'(opb) + 16'd1);
          default: alu_err = 1'b1;
        endcase
      end else begin
        alu_res = 16'(opa & opb);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic m, input logic [3:0] c, input logic [1:0] iv,
                      input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      tick();
      n++;
    end
    check("push_ready", bus.req_ready, 1);
    bus.req_mode      = m;
    bus.req_cmd       = c;
    bus.req_inp_valid = iv;
    bus.req_opa       = a;
    bus.req_opb       = b;
    bus.req_cin       = 1'b0;
    bus.req_valid     = 1'b1;
    tick();
    bus.req_valid     = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc, output int ce_cyc);
    cyc    = 0;
    ce_cyc = 0;
    while (!bus.rsp_valid && cyc < 40) begin
      tick();
      cyc++;
      if (ce) ce_cyc++;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic take_rsp();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("rsp_valid_clear", bus.rsp_valid, 0);
  endtask

  initial begin
    int cyc, ce_cyc;
    logic seen;

    rst               = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_mode      = 1'b0;
    bus.req_cmd       = '0;
    bus.req_inp_valid = '0;
    bus.req_opa       = '0;
    bus.req_opb       = '0;
    bus.req_cin       = 1'b0;
    bus.rsp_ready     = 1'b0;
    repeat (3) tick();
    check("rst_ce", ce, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_opa", opa, 0);
    rst = 1'b0;
    tick();
    check("post_rst_req_ready", bus.req_ready, 1);

    // ADD 200+100
    push(1'b1, 4'd0, 2'b11, 8'd200, 8'd100);
    wait_rsp(cyc, ce_cyc);
    check("add_latency", cyc, 4);
    check("add_ce_cycles", ce_cyc, 3);
    check("add_res", bus.rsp_res, 16'h012C);
    check("add_cout", bus.rsp_cout, 1);
    check("add_err", bus.rsp_err, 0);
    take_rsp();

    // MUL (3+1)*(4+1)
    wait_idle();
    push(1'b1, 4'd9, 2'b11, 8'd3, 8'd4);
    wait_rsp(cyc, ce_cyc);
    check("mul_latency", cyc, 5);
    check("mul_ce_cycles", ce_cyc, 4);
    check("mul_res", bus.rsp_res, 16'd20);
    take_rsp();

    // Compare 5 vs 9
    wait_idle();
    push(1'b1, 4'd8, 2'b11, 8'd5, 8'd9);
    wait_rsp(cyc, ce_cyc);
    check("cmp_egl", bus.rsp_egl, 3'b001);
    check("cmp_res", bus.rsp_res, 0);
    check("cmp_err", bus.rsp_err, 0);
    take_rsp();

    // Operands flagged invalid
    wait_idle();
    push(1'b1, 4'd0, 2'b00, 8'd7, 8'd7);
    wait_rsp(cyc, ce_cyc);
    check("inv_err", bus.rsp_err, 1);
    check("inv_res", bus.rsp_res, 0);
    take_rsp();

    // Backpressure: one in flight plus four queued fills the FIFO
    wait_idle();
    for (int i = 0; i < 5; i++) push(1'b1, 4'd0, 2'b11, 8'(i * 10 + 1), 8'd2);
    check("full_req_ready", bus.req_ready, 0);
    check("full_busy", busy, 1);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp(cyc, ce_cyc);
      check("order_valid", bus.rsp_valid, 1);
      check("order_res", bus.rsp_res, 32'(i * 10 + 3));
      tick();
    end
    bus.rsp_ready = 1'b0;
    wait_idle();
    check("drain_busy", busy, 0);
    check("drain_req_ready", bus.req_ready, 1);

    // Reset while an op is being driven and another is queued
    push(1'b1, 4'd0, 2'b11, 8'd1, 8'd1);
    push(1'b1, 4'd0, 2'b11, 8'd2, 8'd2);
    tick();
    check("pre_rst_ce", ce, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ce", ce, 0);
    check("mid_rst_rsp_valid", bus.rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    bus.rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | bus.rsp_valid;
    end
    check("dropped_no_rsp", seen, 0);
    check("post_mid_rst_ready", bus.req_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
